// File: rtl/acc_tile_seq.sv
// acc_tile_seq: tile-level sequencer for the cubic accumulation buffer.
//
// Takes a per-tile configuration with a start pulse and checks it. It then works out the
// conv/pool output geometry. It gates PE-array partial sums into the buffer across all
// input-channel passes, and issues the new_tile, qtf_start and pooling_start pulses. It counts
// pooled results to detect the end of the tile, then reports done or an error code.
//
// Ports:
//   clock, rst                 clock, asynchronous active-high reset
//   start, abort               tile start (taken only in IDLE), return-to-IDLE request
//   tile_length, tile_height   input tile size incl. padding
//   ksize, stride, pool_size   kernel size, conv stride, 1 = bypass / 2 = 2x2 pooling
//   num_pass                   input-channel accumulation passes
//   pe_valid, pe_buf_end       PE array beat valid / row-buffer end
//   pe_pass_done               pulse on the last beat of a pass
//   res_valid                  pooled result strobe from the buffer
//   pe_ready, psums_valid,     combinational ACCUM gating of the PE array
//   one_buf_end
//   new_tile, qtf_start,       registered 1-cycle pulses
//   pooling_start, done
//   busy                       registered, high outside IDLE
//   err_code                   0 none, 1 bad config, 2 capacity, 3 timeout
module acc_tile_seq #(
  parameter int unsigned PASS_W    = 10,
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned QTF_CYC   = 3,
  parameter int unsigned BUF_DEPTH = 1024,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [5:0]        tile_length,
  input  logic [5:0]        tile_height,
  input  logic [2:0]        ksize,
  input  logic [2:0]        stride,
  input  logic [1:0]        pool_size,
  input  logic [PASS_W-1:0] num_pass,
  input  logic              pe_valid,
  input  logic              pe_buf_end,
  input  logic              pe_pass_done,
  input  logic              res_valid,
  output logic              pe_ready,
  output logic              new_tile,
  output logic              psums_valid,
  output logic              one_buf_end,
  output logic              qtf_start,
  output logic              pooling_start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  localparam int unsigned CntMaxA = (DRAIN_CYC > QTF_CYC) ? DRAIN_CYC : QTF_CYC;
  localparam int unsigned CntMax  = (TIMEOUT > CntMaxA) ? TIMEOUT : CntMaxA;
  localparam int unsigned CntW    = $clog2(CntMax + 1);

  localparam logic [CntW-1:0]   DrainLast = CntW'(DRAIN_CYC - 1);
  localparam logic [CntW-1:0]   QtfLast   = CntW'(QTF_CYC - 1);
  localparam logic [CntW-1:0]   ToLast    = CntW'(TIMEOUT - 1);
  localparam logic [12:0]       BufDepthW = 13'(BUF_DEPTH);
  localparam logic [PASS_W-1:0] PassOne   = PASS_W'(1);

  typedef enum logic [2:0] {
    StIdle, StCheck, StCalc, StClear, StAccum, StDrain, StQtf, StPool
  } state_e;

  state_e state_q;

  // Latched tile configuration
  logic [5:0]        tl_q, th_q;
  logic [2:0]        ks_q, st_q;
  logic [1:0]        ps_q;
  logic [PASS_W-1:0] np_q;

  // Geometry by repeated subtraction: rem_* is what is left of (tile - ksize)
  logic [5:0]        rem_w_q, rem_h_q;
  logic [5:0]        ow_q, oh_q;
  logic [11:0]       exp_cnt_q;
  logic [11:0]       res_cnt_q;
  logic [PASS_W-1:0] pass_cnt_q;
  logic [CntW-1:0]   cyc_q;

  logic        cfg_bad;
  logic        sub_w, sub_h;
  logic [12:0] area;
  logic [5:0]  half_w, half_h;
  logic [11:0] pooled;

  assign cfg_bad = (st_q == 3'd0) || (ks_q == 3'd0) ||
                   ({3'b000, ks_q} > tl_q) || ({3'b000, ks_q} > th_q) ||
                   !((ps_q == 2'd1) || (ps_q == 2'd2)) || (np_q == '0);

  assign sub_w  = rem_w_q >= {3'b000, st_q};
  assign sub_h  = rem_h_q >= {3'b000, st_q};
  assign area   = 13'(ow_q) * 13'(oh_q);
  assign half_w = 6'((7'(ow_q) + 7'd1) >> 1);
  assign half_h = 6'((7'(oh_q) + 7'd1) >> 1);
  assign pooled = 12'(half_w) * 12'(half_h);

  assign pe_ready    = (state_q == StAccum);
  assign psums_valid = pe_valid & (state_q == StAccum);
  assign one_buf_end = pe_buf_end & (state_q == StAccum);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tl_q          <= '0;
      th_q          <= '0;
      ks_q          <= '0;
      st_q          <= '0;
      ps_q          <= '0;
      np_q          <= '0;
      rem_w_q       <= '0;
      rem_h_q       <= '0;
      ow_q          <= '0;
      oh_q          <= '0;
      exp_cnt_q     <= '0;
      res_cnt_q     <= '0;
      pass_cnt_q    <= '0;
      cyc_q         <= '0;
      new_tile      <= 1'b0;
      qtf_start     <= 1'b0;
      pooling_start <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_code      <= 2'd0;
    end else begin
      new_tile      <= 1'b0;
      qtf_start     <= 1'b0;
      pooling_start <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        // Silent return: no pulses, err_code kept
        state_q <= StIdle;
        busy    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              tl_q     <= tile_length;
              th_q     <= tile_height;
              ks_q     <= ksize;
              st_q     <= stride;
              ps_q     <= pool_size;
              np_q     <= num_pass;
              err_code <= 2'd0;
              busy     <= 1'b1;
              state_q  <= StCheck;
            end
          end
          StCheck: begin
            if (cfg_bad) begin
              err_code <= 2'd1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              rem_w_q <= tl_q - {3'b000, ks_q};
              rem_h_q <= th_q - {3'b000, ks_q};
              ow_q    <= 6'd1;
              oh_q    <= 6'd1;
              state_q <= StCalc;
            end
          end
          StCalc: begin
            if (sub_w || sub_h) begin
              if (sub_w) begin
                rem_w_q <= rem_w_q - {3'b000, st_q};
                ow_q    <= ow_q + 6'd1;
              end
              if (sub_h) begin
                rem_h_q <= rem_h_q - {3'b000, st_q};
                oh_q    <= oh_q + 6'd1;
              end
            end else if (area > BufDepthW) begin
              err_code <= 2'd2;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              exp_cnt_q <= (ps_q == 2'd1) ? area[11:0] : pooled;
              new_tile  <= 1'b1;
              state_q   <= StClear;
            end
          end
          StClear: begin
            pass_cnt_q <= '0;
            state_q    <= StAccum;
          end
          StAccum: begin
            if (pe_pass_done) begin
              if (pass_cnt_q == np_q - PassOne) begin
                // The pass_done cycle itself counts as the first drain cycle
                cyc_q   <= CntW'(1);
                state_q <= StDrain;
              end else begin
                pass_cnt_q <= pass_cnt_q + PassOne;
              end
            end
          end
          StDrain: begin
            if (cyc_q >= DrainLast) begin
              cyc_q     <= '0;
              qtf_start <= 1'b1;
              state_q   <= StQtf;
            end else begin
              cyc_q <= cyc_q + CntW'(1);
            end
          end
          StQtf: begin
            if (cyc_q >= QtfLast) begin
              cyc_q         <= '0;
              res_cnt_q     <= '0;
              pooling_start <= 1'b1;
              state_q       <= StPool;
            end else begin
              cyc_q <= cyc_q + CntW'(1);
            end
          end
          StPool: begin
            // Completion wins over a timeout landing on the same cycle
            if (res_valid && (res_cnt_q + 12'd1 == exp_cnt_q)) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end else if (cyc_q >= ToLast) begin
              err_code <= 2'd3;
              done     <= 1'b1;
              busy     <= 1'b0;
              state_q  <= StIdle;
            end else begin
              cyc_q <= cyc_q + CntW'(1);
              if (res_valid) res_cnt_q <= res_cnt_q + 12'd1;
            end
          end
          default: begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acc_tile_seq.sv
// Directed testbench for acc_tile_seq with hand-computed expected values.
module tb_acc_tile_seq;

  localparam int DrainCyc = 3;
  localparam int QtfCyc   = 3;
  localparam int Timeout  = 4096;

  logic       clock, rst, start, abort;
  logic [5:0] tile_length, tile_height;
  logic [2:0] ksize, stride;
  logic [1:0] pool_size;
  logic [9:0] num_pass;
  logic       pe_valid, pe_buf_end, pe_pass_done, res_valid;
  logic       pe_ready, new_tile, psums_valid, one_buf_end;
  logic       qtf_start, pooling_start, busy, done;
  logic [1:0] err_code;

  acc_tile_seq dut (
    .clock         (clock),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .tile_length   (tile_length),
    .tile_height   (tile_height),
    .ksize         (ksize),
    .stride        (stride),
    .pool_size     (pool_size),
    .num_pass      (num_pass),
    .pe_valid      (pe_valid),
    .pe_buf_end    (pe_buf_end),
    .pe_pass_done  (pe_pass_done),
    .res_valid     (res_valid),
    .pe_ready      (pe_ready),
    .new_tile      (new_tile),
    .psums_valid   (psums_valid),
    .one_buf_end   (one_buf_end),
    .qtf_start     (qtf_start),
    .pooling_start (pooling_start),
    .busy          (busy),
    .done          (done),
    .err_code      (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_new = 0, n_qtf = 0, n_pool = 0, n_done = 0;
  int t_qtf = 0, t_pool = 0, t_done = 0;
  int t_pd = 0;
  int base_new, base_qtf, base_pool, base_done;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are read 1 ns after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    if (new_tile) n_new++;
    if (qtf_start) begin n_qtf++; t_qtf = cyc; end
    if (pooling_start) begin n_pool++; t_pool = cyc; end
    if (done) begin n_done++; t_done = cyc; end
  endtask

  // sel: 0 new_tile, 1 qtf_start, 2 pooling_start, 3 done
  task automatic wait_for(input int sel, input int bound, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick();
      case (sel)
        0:       hit = new_tile;
        1:       hit = qtf_start;
        2:       hit = pooling_start;
        default: hit = done;
      endcase
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  task automatic do_start(input logic [5:0] tl, input logic [5:0] th, input logic [2:0] k,
                          input logic [2:0] s, input logic [1:0] p, input logic [9:0] np);
    tile_length = tl;
    tile_height = th;
    ksize       = k;
    stride      = s;
    pool_size   = p;
    num_pass    = np;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic mark();
    base_new  = n_new;
    base_qtf  = n_qtf;
    base_pool = n_pool;
    base_done = n_done;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tile_length = '0; tile_height = '0; ksize = '0; stride = '0; pool_size = '0;
    num_pass = '0; pe_valid = 1'b0; pe_buf_end = 1'b0; pe_pass_done = 1'b0; res_valid = 1'b0;
    tick(); tick();
    check_val("rst busy", 32'(busy), 32'd0);
    check_val("rst done", 32'(done), 32'd0);
    check_val("rst err", 32'(err_code), 32'd0);
    check_val("rst new_tile", 32'(new_tile), 32'd0);
    check_val("rst pe_ready", 32'(pe_ready), 32'd0);
    rst = 1'b0;
    tick();

    // IDLE gating: strobes ignored, abort beats a simultaneous start
    pe_valid = 1'b1; pe_buf_end = 1'b1; res_valid = 1'b1; pe_pass_done = 1'b1;
    #1;
    check_val("idle psums_valid", 32'(psums_valid), 32'd0);
    check_val("idle one_buf_end", 32'(one_buf_end), 32'd0);
    tick(); tick();
    check_val("idle busy", 32'(busy), 32'd0);
    pe_valid = 1'b0; pe_buf_end = 1'b0; res_valid = 1'b0; pe_pass_done = 1'b0;
    abort = 1'b1;
    do_start(6'd16, 6'd16, 3'd3, 3'd1, 2'd2, 10'd2);
    abort = 1'b0;
    check_val("abort+start busy", 32'(busy), 32'd0);
    tick();
    check_val("abort+start still idle", 32'(busy), 32'd0);

    // Tile 1: 16x16 k3 s1 pool2, 2 passes -> ow=oh=14, 7*7=49 pooled results
    mark();
    do_start(6'd16, 6'd16, 3'd3, 3'd1, 2'd2, 10'd2);
    check_val("t1 busy", 32'(busy), 32'd1);
    tile_length = 6'd2; stride = 3'd0; // post-latch changes must not matter
    wait_for(0, 100, "t1 new_tile seen");
    check_val("t1 clear pe_ready", 32'(pe_ready), 32'd0);
    tick();
    check_val("t1 accum pe_ready", 32'(pe_ready), 32'd1);
    pe_valid = 1'b1; pe_buf_end = 1'b1;
    #1;
    check_val("t1 psums_valid", 32'(psums_valid), 32'd1);
    check_val("t1 one_buf_end", 32'(one_buf_end), 32'd1);
    pe_buf_end = 1'b0;
    tick(); tick();
    pe_pass_done = 1'b1;
    tick();
    pe_pass_done = 1'b0;
    check_val("t1 still accum after pass 1", 32'(pe_ready), 32'd1);
    start = 1'b1; // start while busy: ignored
    tick();
    start = 1'b0;
    tick();
    pe_pass_done = 1'b1;
    t_pd = cyc;
    tick();
    pe_pass_done = 0; pe_valid = 0;
    check_val("t1 drain pe_ready", 32'(pe_ready), 32'd0);
    wait_for(1, 20, "t1 qtf_start seen");
    check_val("t1 qtf delay", 32'(t_qtf - t_pd), 32'(DrainCyc));
    wait_for(2, 20, "t1 pooling_start seen");
    check_val("t1 pool delay", 32'(t_pool - t_qtf), 32'(QtfCyc));
    for (int i = 0; i < 48; i++) begin
      res_valid = 1'b1;
      tick();
    end
    check_val("t1 no done at 48", 32'(done), 32'd0);
    check_val("t1 busy at 48", 32'(busy), 32'd1);
    tick(); // 49th beat sampled at this edge
    res_valid = 1'b0;
    check_val("t1 done on 49th", 32'(done), 32'd1);
    check_val("t1 err", 32'(err_code), 32'd0);
    check_val("t1 busy low", 32'(busy), 32'd0);
    check_val("t1 new_tile count", 32'(n_new - base_new), 32'd1);
    check_val("t1 qtf count", 32'(n_qtf - base_qtf), 32'd1);
    check_val("t1 pool count", 32'(n_pool - base_pool), 32'd1);

    // Tile 2, back-to-back: stride 0 -> bad config
    mark();
    do_start(6'd16, 6'd16, 3'd3, 3'd0, 2'd2, 10'd2);
    check_val("t2 check busy", 32'(busy), 32'd1);
    check_val("t2 err cleared on start", 32'(err_code), 32'd0);
    tick();
    check_val("t2 done", 32'(done), 32'd1);
    check_val("t2 err", 32'(err_code), 32'd1);
    check_val("t2 busy low", 32'(busy), 32'd0);
    tick();
    check_val("t2 done is a pulse", 32'(done), 32'd0);
    check_val("t2 err held", 32'(err_code), 32'd1);
    check_val("t2 no new_tile", 32'(n_new - base_new), 32'd0);

    // Tile 3: 34x34 k1 -> 1156 outputs exceed buffer depth
    mark();
    do_start(6'd34, 6'd34, 3'd1, 3'd1, 2'd1, 10'd1);
    wait_for(3, 100, "t3 done seen");
    check_val("t3 err", 32'(err_code), 32'd2);
    check_val("t3 busy low", 32'(busy), 32'd0);
    check_val("t3 no new_tile", 32'(n_new - base_new), 32'd0);

    // Tile 4: 10x10 k3 s2 pool2 -> exp 4, only 3 results -> timeout
    mark();
    do_start(6'd10, 6'd10, 3'd3, 3'd2, 2'd2, 10'd1);
    wait_for(0, 100, "t4 new_tile seen");
    tick();
    pe_pass_done = 1'b1;
    tick();
    pe_pass_done = 1'b0;
    wait_for(2, 20, "t4 pooling_start seen");
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1;
      tick();
    end
    res_valid = 1'b0;
    check_val("t4 busy after 3", 32'(busy), 32'd1);
    wait_for(3, Timeout + 10, "t4 done seen");
    check_val("t4 err", 32'(err_code), 32'd3);
    check_val("t4 timeout length", 32'(t_done - t_pool), 32'(Timeout));

    // Tile 5: abort mid-ACCUM
    mark();
    do_start(6'd16, 6'd16, 3'd3, 3'd1, 2'd2, 10'd2);
    wait_for(0, 100, "t5 new_tile seen");
    tick();
    pe_valid = 1'b1;
    #1;
    check_val("t5 psums_valid before abort", 32'(psums_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t5 psums_valid after abort", 32'(psums_valid), 32'd0);
    check_val("t5 busy", 32'(busy), 32'd0);
    check_val("t5 err unchanged", 32'(err_code), 32'd0);
    pe_pass_done = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    pe_pass_done = 1'b0; pe_valid = 1'b0;
    check_val("t5 no qtf", 32'(n_qtf - base_qtf), 32'd0);
    check_val("t5 no pool", 32'(n_pool - base_pool), 32'd0);
    check_val("t5 no done", 32'(n_done - base_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acc_tile_seq.md
Name: acc_tile_seq

Overview:
- Tile-level sequencer for the cubic accumulation buffer.
- Accepts a per-tile configuration and start pulse; validates it and derives the conv/pool output geometry.
- Gates PE-array partial sums into the buffer across all input-channel passes.
- Issues the new_tile / qtf_start / pooling_start pulses at legal times, counts pooled results to detect tile completion, and reports done or error to the layer controller.

Parameters:
- PASS_W, 10: width of num_pass (input-channel accumulation passes per tile).
- DRAIN_CYC, 3: idle cycles after the last pass before qtf_start; covers the buffer's 2-cycle input delay plus write.
- QTF_CYC, 3: cycles from qtf_start to pooling_start; covers ADD_BIAS plus QTF.
- BUF_DEPTH, 1024: max conv outputs per tile (ow*oh).
- TIMEOUT, 4096: max cycles in POOL without tile completion.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  1-cycle tile start; sampled only in IDLE
- abort  in  1  return to IDLE from any state next cycle
- tile_length  in  6  input tile width incl. padding
- tile_height  in  6  input tile height incl. padding
- ksize  in  3  kernel size
- stride  in  3  conv stride
- pool_size  in  2  1 = bypass, 2 = 2x2 pooling
- num_pass  in  PASS_W  accumulation passes
- pe_valid  in  1  PE array psum beat valid
- pe_buf_end  in  1  PE array row-buffer end (address shift)
- pe_pass_done  in  1  1-cycle pulse on the last beat of a pass
- res_valid  in  1  pooled result strobe from the buffer
- pe_ready  out  1  high only in ACCUM
- new_tile  out  1  1-cycle buffer clear pulse
- psums_valid  out  1  pe_valid & (state==ACCUM)
- one_buf_end  out  1  pe_buf_end & (state==ACCUM)
- qtf_start  out  1  1-cycle pulse
- pooling_start  out  1  1-cycle pulse
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse on tile completion
- err_code  out  2  0 none, 1 bad config, 2 capacity, 3 timeout; held until next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0.
- All outputs are registered except psums_valid, one_buf_end and pe_ready, which are combinational from the registered state.
- IDLE: on start, latch all config inputs and go to CHECK. Config input changes after latch are ignored.
- CHECK (1 cycle): bad config if any of:
  - stride==0
  - ksize==0
  - ksize>tile_length
  - ksize>tile_height
  - pool_size not in {1,2}
  - num_pass==0
  On bad config: err_code=1, done pulse, go to IDLE. Otherwise go to CALC.
- CALC: compute ow=(tile_length-ksize)/stride+1 and oh likewise by repeated subtraction.
  - ow and oh are computed in parallel, one subtract per cycle; at most 63 cycles.
  - Then exp_cnt = ow*oh for pool_size 1, or ceil(ow/2)*ceil(oh/2) for pool_size 2 (12-bit).
  - If ow*oh > BUF_DEPTH: err_code=2, done pulse, go to IDLE.
  - Otherwise go to CLEAR.
- CLEAR (1 cycle): new_tile=1, pass_cnt=0, go to ACCUM.
- ACCUM:
  - Forward psums beats.
  - On pe_pass_done, pass_cnt++; when pass_cnt==num_pass-1 and pe_pass_done, go to DRAIN.
  - pe_pass_done outside ACCUM is ignored.
- DRAIN: count DRAIN_CYC cycles, then go to QTF.
- QTF: qtf_start=1 on the entry cycle; after QTF_CYC cycles, pooling_start=1 for 1 cycle and go to POOL.
- POOL:
  - Count res_valid.
  - When the count reaches exp_cnt: done pulse the same cycle as the registered transition, go to IDLE.
  - If the cycle count reaches TIMEOUT first: err_code=3, done pulse, go to IDLE.
- Gating: res_valid outside POOL is ignored; start while busy is ignored.
- abort: has priority over every transition. Next cycle state=IDLE; no pulses issued; err_code unchanged; done not pulsed.
- Simultaneous start and abort in IDLE: abort wins, start dropped.
- Back-to-back tiles: start in the cycle after done is accepted.

Test Plan:
- 16x16, k3, s1, pool 2, num_pass 2 -> ow=oh=14. Sequence is one new_tile, ACCUM across 2 passes, qtf_start exactly DRAIN_CYC cycles after the 2nd pe_pass_done, pooling_start QTF_CYC cycles later. done on the 49th res_valid; err_code 0.
- stride=0 start -> err_code=1, done pulse 1 cycle after CHECK; no new_tile issued; busy low again within 2 cycles.
- 34x34, k1, s1, pool 1 -> ow*oh=1156 > 1024: err_code=2, no new_tile.
- 10x10, k3, s2, pool 2 -> ow=oh=4, exp_cnt 4. Supply only 3 res_valid -> err_code=3 after TIMEOUT cycles in POOL.
- abort mid-ACCUM with pe_valid high -> psums_valid low the next cycle; IDLE; qtf_start and pooling_start never assert.
- pe_valid and res_valid toggled in IDLE, plus start while busy -> psums_valid stays 0 and no state change.
